cfg_bus_arbiter: RTL and testbench

Two-master arbiter for the switch's 32-bit management configuration bus (cs_n/ack_n/rw/addr/wdata/rdata four-phase handshake). It sits between the management slaves (sync/role/MAC register block and peers) and two requesters: master 0, the host CPU interface, and master 1, the in-band management packet parser. It grants the single slave port round-robin, runs the four-phase handshake on both sides, and optionally aborts transactions the slave never acknowledges.

---
 rtl/cfg_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_cfg_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_bus_arbiter.sv
// Two-master round-robin arbiter for the 32-bit management config bus (cs_n/ack_n four-phase).
// Optional slave-timeout abort is compiled in with `define CFG_ARB_TIMEOUT_EN.
module cfg_bus_arbiter #(
    parameter logic [15:0] TIMEOUT_CYC   = 16'd1024,
    parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_cs_n,
    input  logic        m0_rw,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack_n,
    output logic [31:0] m0_rdata,
    input  logic        m1_cs_n,
    input  logic        m1_rw,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack_n,
    output logic [31:0] m1_rdata,
    output logic        cfg_cs_n,
    output logic        cfg_rw,
    output logic [31:0] cfg_addr,
    output logic [31:0] cfg_wdata,
    input  logic        cfg_ack_n,
    input  logic [31:0] cfg_rdata,
    output logic        timeout_err,
    output logic [15:0] timeout_cnt
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_ACK = 2'd1;
    localparam logic [1:0] RELEASE  = 2'd2;

    if (TIMEOUT_CYC < 16'd2 || $isunknown(TIMEOUT_RDATA)) begin : g_bad_param
        $error("cfg_bus_arbiter: TIMEOUT_CYC must be >= 2 and TIMEOUT_RDATA fully specified");
    end

    logic [1:0]    state, state_d;
    logic          grant, grant_d;
    logic          last_grant, last_grant_d;
    logic          win;
    logic          done;
    logic [DW-1:0] done_rdata;
    logic          cfg_cs_n_d, cfg_rw_d;
    logic [AW-1:0] cfg_addr_d;
    logic [DW-1:0] cfg_wdata_d;
    logic          m0_ack_n_d, m1_ack_n_d;
    logic [DW-1:0] m0_rdata_d, m1_rdata_d;
`ifdef CFG_ARB_TIMEOUT_EN
    logic [15:0]   wait_cnt, wait_cnt_d;
    logic          timeout_err_d;
    logic [15:0]   timeout_cnt_d;
`endif

    // Next-state and next-output decode
    always_comb begin
        state_d      = state;
        grant_d      = grant;
        last_grant_d = last_grant;
        cfg_cs_n_d   = cfg_cs_n;
        cfg_rw_d     = cfg_rw;
        cfg_addr_d   = cfg_addr;
        cfg_wdata_d  = cfg_wdata;
        m0_ack_n_d   = m0_ack_n;
        m1_ack_n_d   = m1_ack_n;
        m0_rdata_d   = m0_rdata;
        m1_rdata_d   = m1_rdata;
        done         = 1'b0;
        done_rdata   = cfg_rdata;
`ifdef CFG_ARB_TIMEOUT_EN
        wait_cnt_d    = wait_cnt;
        timeout_err_d = 1'b0;
        timeout_cnt_d = timeout_cnt;
`endif
        // Sole requester wins; on a tie the master not served last time wins
        win = m0_cs_n ? 1'b1 : (m1_cs_n ? 1'b0 : ~last_grant);

        case (state)
            IDLE: begin
                if (!m0_cs_n || !m1_cs_n) begin
                    grant_d     = win;
                    cfg_rw_d    = win ? m1_rw : m0_rw;
                    cfg_addr_d  = win ? m1_addr : m0_addr;
                    cfg_wdata_d = win ? m1_wdata : m0_wdata;
                    cfg_cs_n_d  = 1'b0;
`ifdef CFG_ARB_TIMEOUT_EN
                    wait_cnt_d  = 16'd0;
`endif
                    state_d     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
`ifdef CFG_ARB_TIMEOUT_EN
                wait_cnt_d = wait_cnt + 16'd1;
`endif
                if (!cfg_ack_n) begin
                    done = 1'b1;
                end
`ifdef CFG_ARB_TIMEOUT_EN
                else if (wait_cnt == TIMEOUT_CYC - 16'd1) begin
                    done          = 1'b1;
                    done_rdata    = TIMEOUT_RDATA;
                    timeout_err_d = 1'b1;
                    if (timeout_cnt != 16'hFFFF) begin
                        timeout_cnt_d = timeout_cnt + 16'd1;
                    end
                end
`endif
            end
            RELEASE: begin
                if (grant ? m1_cs_n : m0_cs_n) begin
                    if (grant) m1_ack_n_d = 1'b1;
                    else       m0_ack_n_d = 1'b1;
                end
                if ((grant ? m1_ack_n : m0_ack_n) && cfg_ack_n) begin
                    last_grant_d = grant;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Completion (slave ack or abort) answers the granted master
        if (done) begin
            cfg_cs_n_d = 1'b1;
            state_d    = RELEASE;
            if (grant) begin
                m1_ack_n_d = 1'b0;
                m1_rdata_d = done_rdata;
            end else begin
                m0_ack_n_d = 1'b0;
                m0_rdata_d = done_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cfg_cs_n   <= 1'b1;
            cfg_rw     <= 1'b0;
            cfg_addr   <= '0;
            cfg_wdata  <= '0;
            m0_ack_n   <= 1'b1;
            m1_ack_n   <= 1'b1;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            state      <= state_d;
            grant      <= grant_d;
            last_grant <= last_grant_d;
            cfg_cs_n   <= cfg_cs_n_d;
            cfg_rw     <= cfg_rw_d;
            cfg_addr   <= cfg_addr_d;
            cfg_wdata  <= cfg_wdata_d;
            m0_ack_n   <= m0_ack_n_d;
            m1_ack_n   <= m1_ack_n_d;
            m0_rdata   <= m0_rdata_d;
            m1_rdata   <= m1_rdata_d;
        end
    end

`ifdef CFG_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= 16'd0;
            timeout_err <= 1'b0;
            timeout_cnt <= 16'd0;
        end else begin
            wait_cnt    <= wait_cnt_d;
            timeout_err <= timeout_err_d;
            timeout_cnt <= timeout_cnt_d;
        end
    end
`else
    assign timeout_err = 1'b0;
    assign timeout_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Directed bench for cfg_bus_arbiter with a behavioural config slave; handles both
// the default build and the CFG_ARB_TIMEOUT_EN build.
module tb_cfg_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_cs_n, m0_rw, m1_cs_n, m1_rw;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack_n, m1_ack_n;
    logic [31:0] m0_rdata, m1_rdata;
    logic        cfg_cs_n, cfg_rw, cfg_ack_n;
    logic [31:0] cfg_addr, cfg_wdata, cfg_rdata;
    logic        timeout_err;
    logic [15:0] timeout_cnt;

    int          n_cmp = 0;
    int          n_err = 0;

    // Slave model controls
    logic        slv_en;
    int          slv_lat;
    logic [31:0] slv_rdata;
    int          slv_wait;
    int          txn_cnt;

    cfg_bus_arbiter #(.TIMEOUT_CYC(16'd16), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cs_n(m0_cs_n), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack_n(m0_ack_n), .m0_rdata(m0_rdata),
        .m1_cs_n(m1_cs_n), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack_n(m1_ack_n), .m1_rdata(m1_rdata),
        .cfg_cs_n(cfg_cs_n), .cfg_rw(cfg_rw), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_ack_n(cfg_ack_n), .cfg_rdata(cfg_rdata),
        .timeout_err(timeout_err), .timeout_cnt(timeout_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Four-phase slave: acks after slv_lat+1 low cycles, releases once cs_n rises
    initial begin
        cfg_ack_n = 1'b1;
        cfg_rdata = 32'h0;
        slv_wait  = 0;
        txn_cnt   = 0;
        forever begin
            @(negedge clk);
            if (!cfg_cs_n && cfg_ack_n && slv_en) begin
                if (slv_wait >= slv_lat) begin
                    cfg_ack_n = 1'b0;
                    cfg_rdata = slv_rdata;
                    txn_cnt++;
                end else begin
                    slv_wait++;
                end
            end else if (cfg_cs_n) begin
                cfg_ack_n = 1'b1;
                slv_wait  = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for a master ack; returns the number of negedges waited
    task automatic wait_ack(input int m, input int limit, input string tag, output int cyc);
        cyc = 0;
        while (((m == 0) ? m0_ack_n : m1_ack_n) !== 1'b0 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, 32'(cyc < limit), 32'd1);
    endtask

    initial begin
        int cyc;
        int who;
        rst_n = 1'b0;
        m0_cs_n = 1'b1; m0_rw = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_cs_n = 1'b1; m1_rw = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
        slv_en = 1'b1; slv_lat = 2; slv_rdata = 32'h0;

        // Reset values
        tick(2);
        chk("rst_m0_ack_n", 32'(m0_ack_n), 32'd1);
        chk("rst_m1_ack_n", 32'(m1_ack_n), 32'd1);
        chk("rst_cfg_cs_n", 32'(cfg_cs_n), 32'd1);
        chk("rst_cfg_addr", cfg_addr, 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Single read by m0
        slv_rdata = 32'h0006_0600;
        m0_rw = 1'b1; m0_addr = 32'h08; m0_cs_n = 1'b0;
        tick(1);
        chk("rd_cfg_cs_n", 32'(cfg_cs_n), 32'd0);
        chk("rd_cfg_rw", 32'(cfg_rw), 32'd1);
        chk("rd_cfg_addr", cfg_addr, 32'h08);
        wait_ack(0, 50, "rd_ack_seen", cyc);
        chk("rd_m0_rdata", m0_rdata, 32'h0006_0600);
        chk("rd_m1_ack_n", 32'(m1_ack_n), 32'd1);
        tick(2);
        chk("rd_ack_held", 32'(m0_ack_n), 32'd0);
        m0_cs_n = 1'b1;
        tick(1);
        chk("rd_ack_release", 32'(m0_ack_n), 32'd1);
        chk("rd_rdata_hold", m0_rdata, 32'h0006_0600);
        tick(1);

        // Write passthrough by m1
        cyc = txn_cnt;
        m1_rw = 1'b0; m1_addr = 32'h00; m1_wdata = 32'h5; m1_cs_n = 1'b0;
        tick(1);
        chk("wr_cfg_cs_n", 32'(cfg_cs_n), 32'd0);
        chk("wr_cfg_rw", 32'(cfg_rw), 32'd0);
        chk("wr_cfg_addr", cfg_addr, 32'h00);
        chk("wr_cfg_wdata", cfg_wdata, 32'h5);
        who = cyc;
        wait_ack(1, 50, "wr_ack_seen", cyc);
        chk("wr_m0_ack_n", 32'(m0_ack_n), 32'd1);
        m1_cs_n = 1'b1;
        tick(4);
        chk("wr_txn_count", 32'(txn_cnt - who), 32'd1);
        chk("wr_cfg_cs_n_idle", 32'(cfg_cs_n), 32'd1);

        // Tie arbitration from fresh reset: m0, m1, m0, m1
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        m0_rw = 1'b1; m0_addr = 32'h100;
        m1_rw = 1'b1; m1_addr = 32'h200;
        m0_cs_n = 1'b0; m1_cs_n = 1'b0;
        for (int r = 0; r < 4; r++) begin
            cyc = 0;
            while (m0_ack_n !== 1'b0 && m1_ack_n !== 1'b0 && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            chk($sformatf("tie%0d_ack_seen", r), 32'(cyc < 50), 32'd1);
            who = (m0_ack_n === 1'b0) ? 0 : 1;
            chk($sformatf("tie%0d_winner", r), 32'(who), 32'(r % 2));
            chk($sformatf("tie%0d_cfg_addr", r), cfg_addr, (r % 2 == 0) ? 32'h100 : 32'h200);
            chk($sformatf("tie%0d_other_ack", r), 32'(who == 0 ? m1_ack_n : m0_ack_n), 32'd1);
            if (r == 3) begin
                m0_cs_n = 1'b1; m1_cs_n = 1'b1;
            end else if (who == 0) begin
                m0_cs_n = 1'b1; tick(1); m0_cs_n = 1'b0;
            end else begin
                m1_cs_n = 1'b1; tick(1); m1_cs_n = 1'b0;
            end
        end
        tick(4);
        chk("tie_bus_idle", 32'(cfg_cs_n), 32'd1);

        // Early withdrawal: ack pulses for exactly one cycle
        slv_lat = 4; slv_rdata = 32'h1234_5678;
        m0_rw = 1'b1; m0_addr = 32'h0C; m0_cs_n = 1'b0;
        tick(2);
        m0_cs_n = 1'b1;
        wait_ack(0, 50, "ew_ack_seen", cyc);
        chk("ew_m0_rdata", m0_rdata, 32'h1234_5678);
        cyc = 0;
        while (m0_ack_n === 1'b0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("ew_ack_width", 32'(cyc), 32'd1);
        m1_rw = 1'b1; m1_addr = 32'h44; m1_cs_n = 1'b0;
        tick(2);
        chk("ew_next_grant_cs", 32'(cfg_cs_n), 32'd0);
        chk("ew_next_grant_addr", cfg_addr, 32'h44);
        wait_ack(1, 50, "ew_next_ack_seen", cyc);
        m1_cs_n = 1'b1;
        tick(3);

        // Unacknowledged transaction
        slv_en = 1'b0;
        m0_rw = 1'b1; m0_addr = 32'h10; m0_cs_n = 1'b0;
        tick(1);
        chk("to_cfg_cs_n", 32'(cfg_cs_n), 32'd0);
`ifdef CFG_ARB_TIMEOUT_EN
        cyc = 0;
        while (m0_ack_n !== 1'b0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("to_latency", 32'(cyc), 32'd16);
        chk("to_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("to_err_pulse", 32'(timeout_err), 32'd1);
        chk("to_cnt", 32'(timeout_cnt), 32'd1);
        chk("to_cfg_cs_n_high", 32'(cfg_cs_n), 32'd1);
        tick(1);
        chk("to_err_clear", 32'(timeout_err), 32'd0);
        m0_cs_n = 1'b1;
        tick(3);
`else
        tick(40);
        chk("to_no_ack", 32'(m0_ack_n), 32'd1);
        chk("to_still_waiting", 32'(cfg_cs_n), 32'd0);
        chk("to_cnt_zero", 32'(timeout_cnt), 32'd0);
        chk("to_err_zero", 32'(timeout_err), 32'd0);
`endif

        // Reset mid-transaction, then a normal m1 grant
        m0_addr = 32'h14; m0_cs_n = 1'b0;
        tick(3);
        chk("mr_cfg_cs_n_busy", 32'(cfg_cs_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_cfg_cs_n", 32'(cfg_cs_n), 32'd1);
        chk("mr_m0_ack_n", 32'(m0_ack_n), 32'd1);
        chk("mr_cfg_addr", cfg_addr, 32'h0);
        chk("mr_m0_rdata", m0_rdata, 32'h0);
        chk("mr_timeout_cnt", 32'(timeout_cnt), 32'd0);
        m0_cs_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        slv_en = 1'b1; slv_lat = 2; slv_rdata = 32'hA5A5_5A5A;
        m1_rw = 1'b1; m1_addr = 32'h18; m1_cs_n = 1'b0;
        tick(1);
        chk("mr_m1_grant_cs", 32'(cfg_cs_n), 32'd0);
        chk("mr_m1_grant_addr", cfg_addr, 32'h18);
        wait_ack(1, 50, "mr_m1_ack_seen", cyc);
        chk("mr_m1_rdata", m1_rdata, 32'hA5A5_5A5A);
        m1_cs_n = 1'b1;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
